// File: rtl/life_row_stepper.sv
// life_row_stepper
//   Game of Life generation engine. Accepts one W x H frame row by row over a
//   valid/ready stream, buffers it, then streams out the next generation row
//   by row. The sequencer alternates between LOAD (accepting H rows) and EMIT
//   (producing H rows); frames never overlap.
//
//   Build option: define LIFE_WRAP_EN for a toroidal grid (top/bottom and
//   left/right edges are neighbours). Without it, cells outside the grid are
//   dead.
module life_row_stepper #(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int GW = 16
) (
    input  logic          clk,
    input  logic          _rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_row,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_row,
    output logic          out_last,
    output logic [GW-1:0] gen_count
);

    localparam int            RW       = (H > 1) ? $clog2(H) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q,   row_d;
    logic [GW-1:0] gen_q,   gen_d;
    logic [W-1:0]  frame_q [H];

    logic          in_fire;
    logic          out_fire;
    logic          row_is_last;

    logic [W-1:0]  row_up;
    logic [W-1:0]  row_mid;
    logic [W-1:0]  row_dn;
    logic [W+1:0]  ext_up;
    logic [W+1:0]  ext_mid;
    logic [W+1:0]  ext_dn;
    logic [W-1:0]  next_row;

    // Next state of one cell from its 3x3 neighbourhood (centre is mid[1]).
    function automatic logic cell_next(input logic [2:0] up,
                                       input logic [2:0] mid,
                                       input logic [2:0] dn);
        logic [3:0] n;
        n = 4'(up[0]) + 4'(up[1]) + 4'(up[2])
          + 4'(mid[0])            + 4'(mid[2])
          + 4'(dn[0]) + 4'(dn[1]) + 4'(dn[2]);
        return (n == 4'd3) || (mid[1] && (n == 4'd2));
    endfunction

    assign row_is_last = (row_q == ROW_LAST);
    assign in_fire     = (state_q == ST_LOAD) && in_valid;
    assign out_fire    = (state_q == ST_EMIT) && out_ready;

    // Sequencer next-state: count rows in, switch to EMIT, count rows out, back to LOAD.
    always_comb begin
        // NOTE: every _d signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        row_d   = row_q;
        gen_d   = gen_q;
        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    if (row_is_last) begin
                        row_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    if (row_is_last) begin
                        row_d   = '0;
                        gen_d   = gen_q + GW'(1);
                        state_d = ST_LOAD;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Sequencer registers: state, row counter and generation counter.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= ST_LOAD;
            row_q   <= '0;
            gen_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q <= state_d;
            row_q   <= row_d;
            gen_q   <= gen_d;
        end
    end

    // Frame buffer: one row written per accepted input beat, never touched in EMIT.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            // NOTE: the buffer is cleared on reset so a discarded partial frame can never leak into a later one.
            for (int i = 0; i < H; i++) begin
                frame_q[i] <= '0;
            end
        end else if (in_fire) begin
            frame_q[row_q] <= in_row;
        end
    end

    // Select the rows above, at and below the current output row.
    always_comb begin
        row_mid = frame_q[row_q];

        if (row_q == '0) begin
`ifdef LIFE_WRAP_EN
            row_up = frame_q[H-1];
`else
            row_up = '0;
`endif
        end else begin
            row_up = frame_q[row_q - RW'(1)];
        end

        if (row_is_last) begin
`ifdef LIFE_WRAP_EN
            row_dn = frame_q[0];
`else
            row_dn = '0;
`endif
        end else begin
            row_dn = frame_q[row_q + RW'(1)];
        end
    end

    // Pad each row with one column on either side; bit c+1 of ext_* is column c.
`ifdef LIFE_WRAP_EN
    assign ext_up  = {row_up[0],  row_up,  row_up[W-1]};
    assign ext_mid = {row_mid[0], row_mid, row_mid[W-1]};
    assign ext_dn  = {row_dn[0],  row_dn,  row_dn[W-1]};
`else
    assign ext_up  = {1'b0, row_up,  1'b0};
    assign ext_mid = {1'b0, row_mid, 1'b0};
    assign ext_dn  = {1'b0, row_dn,  1'b0};
`endif

    // Apply the cell rule across the whole row.
    always_comb begin
        next_row = '0;
        for (int c = 0; c < W; c++) begin
            next_row[c] = cell_next(ext_up[c +: 3], ext_mid[c +: 3], ext_dn[c +: 3]);
        end
    end

    // Outputs are decoded from registered state, so they hold while the consumer stalls.
    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_EMIT);
    assign out_row   = out_valid ? next_row : '0;
    assign out_last  = out_valid && row_is_last;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_row_stepper.sv
// tb_life_row_stepper
//   Self-checking bench for life_row_stepper (8x8, 16-bit generation counter).
//   Directed frame table, hand-written backpressure / reset / back-to-back
//   sequences, then random frames against a grid-level Game of Life model.
//   Honours LIFE_WRAP_EN in the same way as the design.
module tb_life_row_stepper;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          _rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_row;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_row;
    logic          out_last;
    logic [GW-1:0] gen_count;

    life_row_stepper #(.W(W), .H(H), .GW(GW)) dut (
        .clk       (clk),
        ._rst      (_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    // One directed frame: input frame and expected next generation.
    // Row r of a frame lives in bits [r*W +: W].
    typedef struct packed {
        logic [63:0] in_f;
        logic [63:0] want_f;
    } vec_t;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [GW-1:0] gen_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [63:0] frame8(input logic [7:0] r0, input logic [7:0] r1,
                                           input logic [7:0] r2, input logic [7:0] r3,
                                           input logic [7:0] r4, input logic [7:0] r5,
                                           input logic [7:0] r6, input logic [7:0] r7);
        return {r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    // Reference model: count live neighbours of every cell over the whole grid.
    function automatic logic [63:0] life_model(input logic [63:0] f);
        logic [63:0] nf;
        int n;
        int rr;
        int cc;
        nf = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
`ifdef LIFE_WRAP_EN
                        rr = (rr + H) % H;
                        cc = (cc + W) % W;
`else
                        if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
`endif
                        n += int'(f[rr*W + cc]);
                    end
                end
                nf[r*W + c] = (n == 3) || (f[r*W + c] && n == 2);
            end
        end
        return nf;
    endfunction

    // Feed the first nrows rows of f; starts and ends on a falling edge.
    task automatic send_frame(input logic [63:0] f, input int nrows);
        int cnt;
        for (int r = 0; r < nrows; r++) begin
            cnt = 0;
            while (!in_ready && cnt < 64) begin
                @(negedge clk);
                cnt++;
            end
            check($sformatf("in_ready before row %0d", r), 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_row   = f[r*W +: W];
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_row   = '0;
        if (nrows == H) begin
            check("out_valid one cycle after last input", 64'(out_valid), 64'd1);
            check("in_ready low in emit", 64'(in_ready), 64'd0);
        end
    endtask

    // Drain one frame, optionally stalling stall_n cycles on stall_row.
    // Must start on the falling edge where the first output row is presented.
    task automatic recv_frame(input string name, input logic [63:0] want,
                              input logic [GW-1:0] gen_want,
                              input int stall_row, input int stall_n);
        out_ready = 1'b1;
        for (int r = 0; r < H; r++) begin
            if (r == stall_row && stall_n > 0) begin
                out_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    check($sformatf("%s stall%0d valid", name, k), 64'(out_valid), 64'd1);
                    check($sformatf("%s stall%0d row%0d", name, k, r), 64'(out_row), 64'(want[r*W +: W]));
                    check($sformatf("%s stall%0d last", name, k), 64'(out_last), 64'(r == H-1));
                    check($sformatf("%s stall%0d in_ready", name, k), 64'(in_ready), 64'd0);
                    @(posedge clk);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check($sformatf("%s valid row%0d", name, r), 64'(out_valid), 64'd1);
            check($sformatf("%s out_row row%0d", name, r), 64'(out_row), 64'(want[r*W +: W]));
            check($sformatf("%s out_last row%0d", name, r), 64'(out_last), 64'(r == H-1));
            @(posedge clk);
            @(negedge clk);
        end
        check($sformatf("%s back to load valid", name), 64'(out_valid), 64'd0);
        check($sformatf("%s back to load ready", name), 64'(in_ready), 64'd1);
        check($sformatf("%s gen_count", name), 64'(gen_count), 64'(gen_want));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [4];
        logic [63:0] blinker_h;
        logic [63:0] blinker_v;
        logic [63:0] f;
        logic [63:0] corners;

        blinker_h = frame8(8'h00, 8'h00, 8'h00, 8'b00011100, 8'h00, 8'h00, 8'h00, 8'h00);
        blinker_v = frame8(8'h00, 8'h00, 8'b00001000, 8'b00001000, 8'b00001000, 8'h00, 8'h00, 8'h00);
        corners   = frame8(8'b10000001, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'b10000001);

        vecs[0].in_f   = blinker_h;
        vecs[0].want_f = blinker_v;
        vecs[1].in_f   = frame8(8'h00, 8'b00000110, 8'b00000110, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[1].want_f = vecs[1].in_f;
        vecs[2].in_f   = corners;
`ifdef LIFE_WRAP_EN
        vecs[2].want_f = corners;
`else
        vecs[2].want_f = '0;
`endif
        vecs[3].in_f   = blinker_v;
        vecs[3].want_f = blinker_h;

        // Reset state.
        _rst      = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_row", 64'(out_row), 64'd0);
        check("reset out_last", 64'(out_last), 64'd0);
        check("reset gen_count", 64'(gen_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        _rst    = 1'b1;
        gen_exp = '0;

        // Directed frame table.
        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i].in_f, H);
            gen_exp++;
            recv_frame($sformatf("vec%0d", i), vecs[i].want_f, gen_exp, -1, 0);
        end

        // Backpressure on row 3 with a stray in_valid that must be ignored.
        send_frame(blinker_h, H);
        in_valid = 1'b1;
        in_row   = 8'hFF;
        gen_exp++;
        recv_frame("backpressure", blinker_v, gen_exp, 3, 5);
        in_valid = 1'b0;
        in_row   = '0;

        // Random frames against the model, random stalls.
        for (int i = 0; i < 20; i++) begin
            f = {$urandom(), $urandom()};
            send_frame(f, H);
            gen_exp++;
            recv_frame($sformatf("rand%0d", i), life_model(f), gen_exp,
                       int'($urandom_range(0, H-1)), int'($urandom_range(0, 3)));
        end

        // Async reset in the middle of a load, between clock edges.
        send_frame(blinker_v, 4);
        #2 _rst = 1'b0;
        #1;
        check("midload reset out_valid", 64'(out_valid), 64'd0);
        check("midload reset in_ready", 64'(in_ready), 64'd1);
        check("midload reset gen_count", 64'(gen_count), 64'd0);
        @(negedge clk);
        _rst    = 1'b1;
        gen_exp = '0;
        send_frame(blinker_h, H);
        gen_exp++;
        recv_frame("after reset", blinker_v, gen_exp, -1, 0);

        // Back-to-back: feed the second frame as soon as in_ready rises.
        _rst = 1'b0;
        @(negedge clk);
        _rst    = 1'b1;
        gen_exp = '0;
        send_frame(blinker_h, H);
        gen_exp++;
        recv_frame("b2b first", blinker_v, gen_exp, -1, 0);
        send_frame(blinker_v, H);
        gen_exp++;
        recv_frame("b2b second", blinker_h, gen_exp, -1, 0);
        check("b2b gen_count two", 64'(gen_count), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
